mem_interface: RTL

Sequential memory-interface stage between the single-bus datapath and the word-addressed system RAM. It holds the MAR and MDR, loads them from BusMuxOut under datapath control, and runs one read or write transaction at a time against a variable-latency memory port using a req/ack handshake with a timeout. MDR_q feeds the bus encoder as the MDR source; the control sequencer stalls on busy and advances on done.

---
 rtl/mem_interface.sv | 134 +++++++++++++
 1 files changed

// File: rtl/mem_interface.sv
// mem_interface: MAR/MDR holding stage that runs one read or write at a time
// against a variable-latency req/ack memory port, aborting after TIMEOUT idle waits.
`default_nettype none

module mem_interface #(
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [31:0]       BusMuxOut,
  input  logic              MARin,
  input  logic              MDRin,
  input  logic              rd_req,
  input  logic              wr_req,
  output logic [31:0]       MDR_q,
  output logic [ADDR_W-1:0] MAR_q,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [31:0]       mdr_q, mdr_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              wait_w;
  logic              expire_w;

  assign wait_w   = (state_q == S_RD) || (state_q == S_WR);
  // Expiry is judged on the count this edge would produce, so an ack on that edge still wins.
  assign expire_w = (cnt_q == (TIMEOUT_C - 8'd1));

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (rd_req) begin
          state_d = S_RD;
        end else if (wr_req) begin
          state_d = S_WR;
        end
      end
      S_RD, S_WR: begin
        if (mem_ack || expire_w) begin
          state_d = S_FIN;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy   = (state_q != S_IDLE);
    done   = (state_q == S_FIN);
    mem_rd = (state_q == S_RD);
    mem_wr = (state_q == S_WR);
  end

  always_comb begin
    mar_d = mar_q;
    mdr_d = mdr_q;
    cnt_d = cnt_q;
    err_d = err_q;
    if (state_q == S_IDLE) begin
      if (MARin) begin
        mar_d = BusMuxOut[ADDR_W-1:0];
      end
      if (MDRin) begin
        mdr_d = BusMuxOut;
      end
      if (rd_req || wr_req) begin
        err_d = 1'b0;
        cnt_d = 8'd0;
      end
    end else if (wait_w) begin
      if (mem_ack) begin
        if (state_q == S_RD) begin
          mdr_d = mem_rdata;
        end
      end else if (expire_w) begin
        err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      mar_q <= '0;
      mdr_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      mar_q <= mar_d;
      mdr_q <= mdr_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign MAR_q     = mar_q;
  assign MDR_q     = mdr_q;
  assign err       = err_q;
  assign mem_addr  = mar_q;
  assign mem_wdata = mdr_q;

endmodule

`default_nettype wire
